ysyx_25040111_mem_arb: RTL and testbench

Two-requester memory arbiter that sits directly upstream of the core's load/store unit. It replaces the inline mux-based arbiter between instruction-cache refill and data access. It accepts requests from the icache refill path (port I) and the execute/data path (port D), grants one at a time, and registers the winning request's fields into the LSU command interface. It counts returned beats so that a burst refill completes only after its last beat.

---
 rtl/ysyx_25040111_mem_arb.sv | 154 +++++++++++++++
 tb/tb_ysyx_25040111_mem_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_mem_arb
// Brief    : Two-port (icache refill / data) fixed-priority arbiter feeding
//            the LSU command interface, with burst beat counting.
// Revision : 1.0 - initial release
// ============================================================================

module ysyx_25040111_mem_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 8
) (
  input  logic          clock,
  input  logic          reset,
  // icache refill port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic [LW-1:0] i_len,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic          i_done,
  // data port
  input  logic          d_req,
  input  logic          d_wen,
  input  logic          d_ren,
  input  logic          d_sign,
  input  logic [1:0]    d_mask,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  // LSU command interface
  output logic          m_start,
  output logic          m_wen,
  output logic          m_ren,
  output logic          m_sign,
  output logic [1:0]    m_mask,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [LW-1:0] m_tlen,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_valid,
  output logic          err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [LW-1:0] r_cnt;
  logic          w_idle;
  logic          w_i_beat;
  logic          w_d_beat;
  logic          w_last;

  assign w_idle   = (r_state == S_IDLE);
  assign w_i_beat = (r_state == S_BUSY_I) && m_valid;
  assign w_d_beat = (r_state == S_BUSY_D) && m_valid;
  assign w_last   = (r_cnt == '0);

  // Grants are combinational; masked by reset so nothing leaks while held.
  assign d_gnt    = w_idle && d_req && !reset;
  assign i_gnt    = w_idle && !d_req && i_req && !reset;

  assign i_rvalid = w_i_beat;
  assign i_done   = w_i_beat && w_last;
  assign d_done   = w_d_beat;
  assign rdata    = m_rdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (d_gnt)      w_state_nxt = S_BUSY_D;
        else if (i_gnt) w_state_nxt = S_BUSY_I;
      end
      S_BUSY_I: if (i_done) w_state_nxt = S_IDLE;
      S_BUSY_D: if (d_done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command fields are captured at grant and held until the next grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_start <= 1'b0;
      m_wen   <= 1'b0;
      m_ren   <= 1'b0;
      m_sign  <= 1'b0;
      m_mask  <= 2'b00;
      m_addr  <= '0;
      m_wdata <= '0;
      m_tlen  <= '0;
    end else begin
      m_start <= d_gnt || i_gnt;
      if (d_gnt) begin
        m_wen   <= d_wen;
        m_ren   <= d_ren;
        m_sign  <= d_sign;
        m_mask  <= d_mask;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_tlen  <= '0;
      end else if (i_gnt) begin
        m_wen   <= 1'b0;
        m_ren   <= 1'b1;
        m_sign  <= 1'b0;
        m_mask  <= 2'b11;
        m_addr  <= i_addr;
        m_wdata <= '0;
        m_tlen  <= i_len;
      end
    end
  end

  // Remaining-beats counter; holds at zero on the final beat so a full
  // 2**LW-beat burst never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (d_gnt) begin
      r_cnt <= '0;
    end else if (i_gnt) begin
      r_cnt <= i_len;
    end else if ((w_i_beat || w_d_beat) && !w_last) begin
      r_cnt <= r_cnt - LW'(1);
    end
  end

  // Sticky: a response with no transaction outstanding, or one racing the
  // command start, is a protocol violation by the LSU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (m_valid && (w_idle || m_start)) begin
      err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040111_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25040111_mem_arb
// Brief    : Directed self-checking bench for ysyx_25040111_mem_arb.
// Revision : 1.0 - initial release
// ============================================================================

module tb_ysyx_25040111_mem_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [7:0]  i_len = '0;
  logic        i_gnt, i_rvalid, i_done;
  logic        d_req = 1'b0, d_wen = 1'b0, d_ren = 1'b0, d_sign = 1'b0;
  logic [1:0]  d_mask = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_done;
  logic [31:0] rdata;
  logic        m_start, m_wen, m_ren, m_sign;
  logic [1:0]  m_mask;
  logic [31:0] m_addr, m_wdata;
  logic [7:0]  m_tlen;
  logic [31:0] m_rdata = '0;
  logic        m_valid = 1'b0;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ysyx_25040111_mem_arb #(.AW(32), .DW(32), .LW(8)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_wen(d_wen), .d_ren(d_ren), .d_sign(d_sign),
    .d_mask(d_mask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata),
    .m_start(m_start), .m_wen(m_wen), .m_ren(m_ren), .m_sign(m_sign),
    .m_mask(m_mask), .m_addr(m_addr), .m_wdata(m_wdata), .m_tlen(m_tlen),
    .m_rdata(m_rdata), .m_valid(m_valid), .err(err)
  );

  logic any_out;
  assign any_out = |{i_gnt, i_rvalid, i_done, d_gnt, d_done, m_start, m_wen,
                     m_ren, m_sign, m_mask, m_addr, m_wdata, m_tlen, err};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int done_cnt;
  int done_at;

  initial begin
    // reset, then idle with no requests
    tick(); tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_outputs_zero", 64'(any_out), 64'd0);
    end

    // single data load
    d_req = 1'b1; d_ren = 1'b1; d_mask = 2'b10; d_addr = 32'h8000_0010;
    #1;
    chk("d_gnt_cycle0", 64'(d_gnt), 64'd1);
    chk("i_gnt_cycle0", 64'(i_gnt), 64'd0);
    tick();
    d_req = 1'b0;
    chk("d_m_start", 64'(m_start), 64'd1);
    chk("d_m_addr", 64'(m_addr), 64'h8000_0010);
    chk("d_m_tlen", 64'(m_tlen), 64'd0);
    chk("d_m_ren_mask", 64'({m_ren, m_wen, m_mask}), 64'b1010);
    tick();
    chk("d_m_start_pulse", 64'(m_start), 64'd0);
    tick();
    m_valid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("d_done", 64'(d_done), 64'd1);
    chk("d_rdata", 64'(rdata), 64'hDEAD_BEEF);
    tick();
    m_valid = 1'b0; d_ren = 1'b0;
    #1;
    chk("d_back_idle", 64'({d_done, d_gnt, m_start, err}), 64'd0);

    // 4-beat icache refill
    i_req = 1'b1; i_addr = 32'hA000_0000; i_len = 8'd3;
    #1;
    chk("i_gnt", 64'(i_gnt), 64'd1);
    tick();
    i_req = 1'b0;
    chk("i_m_start_addr", 64'({m_start, m_addr}), {31'd0, 1'b1, 32'hA000_0000});
    chk("i_m_fields", 64'({m_ren, m_wen, m_sign, m_mask, m_tlen}), {51'd0, 5'b10011, 8'd3});
    tick();
    for (int b = 0; b < 4; b++) begin
      m_valid = 1'b1;
      #1;
      chk("i_rvalid_beat", 64'(i_rvalid), 64'd1);
      chk("i_done_beat", 64'(i_done), 64'(b == 3));
      chk("i_tlen_held", 64'(m_tlen), 64'd3);
      tick();
    end
    m_valid = 1'b0;
    #1;
    chk("i_after_burst", 64'({i_done, i_rvalid, err}), 64'd0);

    // simultaneous requests: D wins, one idle cycle, then I
    i_req = 1'b1; i_len = 8'd0; i_addr = 32'hA000_0100;
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'h1234_5678;
    #1;
    chk("both_d_first", 64'({d_gnt, i_gnt}), 64'b10);
    tick();
    d_req = 1'b0; d_wen = 1'b0;
    chk("both_d_cmd", 64'({m_start, m_wen, m_wdata}), {30'd0, 2'b11, 32'h1234_5678});
    chk("both_no_i_gnt_busy", 64'(i_gnt), 64'd0);
    tick();
    m_valid = 1'b1;
    #1;
    chk("both_d_done", 64'({d_done, i_gnt}), 64'b10);
    tick();
    m_valid = 1'b0;
    #1;
    chk("both_idle_i_gnt", 64'({i_gnt, m_start}), 64'b10);
    tick();
    i_req = 1'b0;
    chk("both_i_cmd", 64'({m_start, m_wen, m_addr}), {30'd0, 2'b10, 32'hA000_0100});
    tick();
    m_valid = 1'b1;
    #1;
    chk("both_i_done", 64'(i_done), 64'd1);
    tick();
    m_valid = 1'b0;

    // maximum-length burst: 256 beats, one done on the last
    i_req = 1'b1; i_len = 8'd255;
    tick();
    i_req = 1'b0;
    tick();
    done_cnt = 0; done_at = -1;
    for (int b = 0; b < 256; b++) begin
      m_valid = 1'b1;
      #1;
      if (i_done) begin done_cnt++; done_at = b; end
      tick();
    end
    m_valid = 1'b0;
    #1;
    chk("long_done_count", 64'(done_cnt), 64'd1);
    chk("long_done_beat", 64'(done_at), 64'd255);
    chk("long_err_clear", 64'(err), 64'd0);

    // stray response while idle sets a sticky error
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    chk("err_set", 64'(err), 64'd1);
    d_req = 1'b1; d_ren = 1'b1; d_addr = 32'h0000_0200;
    tick();
    d_req = 1'b0;
    tick();
    m_valid = 1'b1;
    #1;
    chk("err_d_done", 64'(d_done), 64'd1);
    tick();
    m_valid = 1'b0; d_ren = 1'b0;
    chk("err_sticky", 64'(err), 64'd1);

    // reset in the middle of an 8-beat burst
    i_req = 1'b1; i_len = 8'd7; i_addr = 32'hA000_0200;
    tick();
    i_req = 1'b0;
    tick();
    m_valid = 1'b1;
    tick();
    tick();
    m_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs_zero", 64'(any_out), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_after_zero", 64'(any_out), 64'd0);
    d_req = 1'b1; d_ren = 1'b1; d_addr = 32'h8000_0040;
    #1;
    chk("rst_d_gnt", 64'(d_gnt), 64'd1);
    tick();
    d_req = 1'b0;
    chk("rst_d_cmd", 64'({m_start, m_addr}), {31'd0, 1'b1, 32'h8000_0040});
    tick();
    m_valid = 1'b1;
    #1;
    chk("rst_d_done_no_i", 64'({d_done, i_done}), 64'b10);
    tick();
    m_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
